// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and register constants for the ADC SPI target
package adc_pkg;

    typedef enum logic [1:0] {
        LaneModeOne  = 2'b00,
        LaneModeTwo  = 2'b01,
        LaneModeFour = 2'b10
    } lane_md_t;

    typedef enum logic {
        CNV        = 1'b0,
        REG_ACCESS = 1'b1
    } device_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        READY = 2'd2
    } cnv_state_t;

    localparam logic [14:0] ExitReg         = 15'h0014;
    localparam logic [14:0] ModeReg         = 15'h0020;
    localparam logic [2:0]  RegAccessPrefix = 3'b101;

    // The reserved encoding 11 falls back to a single lane.
    function automatic logic [2:0] lane_count(input logic [1:0] md);
        case (md)
            LaneModeTwo:  return 3'd2;
            LaneModeFour: return 3'd4;
            default:      return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/adc_sync_edge.sv
// rtl/adc_sync_edge.sv - pin synchronizer with rise/fall pulses
module adc_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chain <= {STAGES{INIT}};
            prev  <= INIT;
        end else begin
            chain <= (chain << 1) | STAGES'(din);
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/adc_spi_target.sv
// rtl/adc_spi_target.sv - clk-oversampled SPI target emulating the ADC
module adc_spi_target
    import adc_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CNV_CYCLES  = 28,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  spi_resetn,
    input  logic                  cnv,
    output logic                  busy,
    input  logic                  sck,
    input  logic                  csn,
    input  logic                  sdi,
    output logic [3:0]            sdo,
    input  logic [DATA_WIDTH-1:0] sample_data,
    output logic [23:0]           reg_cmd,
    output logic                  reg_cmd_stb,
    output logic [1:0]            lane_md,
    output logic                  reg_mode
);

    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam int CW = $clog2(CNV_CYCLES + 1);

    logic cnv_lvl, cnv_rise, cnv_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic csn_lvl, csn_rise, csn_fall;
    logic sdi_lvl, sdi_rise, sdi_fall;
    logic rst_lvl, rst_rise, rst_fall;

    adc_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_cnv (
        .clk(clk), .resetn(resetn), .din(cnv), .level(cnv_lvl), .rise(cnv_rise), .fall(cnv_fall));
    adc_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sck (
        .clk(clk), .resetn(resetn), .din(sck), .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
    adc_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_csn (
        .clk(clk), .resetn(resetn), .din(csn), .level(csn_lvl), .rise(csn_rise), .fall(csn_fall));
    adc_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sdi (
        .clk(clk), .resetn(resetn), .din(sdi), .level(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall));
    adc_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_rst (
        .clk(clk), .resetn(resetn), .din(spi_resetn), .level(rst_lvl), .rise(rst_rise), .fall(rst_fall));

    logic unused_edges;
    assign unused_edges = &{1'b0, cnv_lvl, cnv_fall, sck_lvl, sck_fall, sdi_rise, sdi_fall, rst_rise, rst_fall};

    logic                  clr;
    logic [23:0]           sh, sh_next;
    device_mode_t          dev_mode;
    cnv_state_t            state;
    logic [CW-1:0]         cnt;
    logic                  data_ready;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [IW-1:0]         idx;
    logic [2:0]            n_lanes;
    logic [3:0]            sdo_next;
    logic                  readout_step;

    assign clr          = ~rst_lvl;
    assign reg_mode     = (dev_mode == REG_ACCESS);
    assign n_lanes      = lane_count(lane_md);
    assign readout_step = (dev_mode == CNV) && !csn_lvl && data_ready && sck_rise;

    // A sck rise coinciding with csn rise still lands in the command word.
    always_comb begin
        sh_next = sh;
        if (csn_fall)
            sh_next = '0;
        else if (sck_rise && (!csn_lvl || csn_rise))
            sh_next = {sh[22:0], sdi_lvl};
    end

    always_comb begin
        sdo_next = '0;
        for (int k = 0; k < 4; k++)
            if (k < int'(n_lanes))
                sdo_next[k] = shift_reg[DATA_WIDTH-1-k];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sh          <= '0;
            reg_cmd     <= '0;
            reg_cmd_stb <= 1'b0;
            lane_md     <= LaneModeOne;
            dev_mode    <= CNV;
        end else if (clr) begin
            sh          <= '0;
            reg_cmd     <= '0;
            reg_cmd_stb <= 1'b0;
            lane_md     <= LaneModeOne;
            dev_mode    <= CNV;
        end else begin
            sh          <= sh_next;
            reg_cmd_stb <= csn_rise;
            if (csn_rise) begin
                reg_cmd <= sh_next;
                if (sh_next[23:21] == RegAccessPrefix)
                    dev_mode <= REG_ACCESS;
                else if (dev_mode == REG_ACCESS && sh_next[23:8] == {1'b0, ModeReg})
                    lane_md <= sh_next[7:6];
                else if (dev_mode == REG_ACCESS && sh_next[23:8] == {1'b0, ExitReg} && sh_next[0])
                    dev_mode <= CNV;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            cnt        <= '0;
            data_ready <= 1'b0;
            shift_reg  <= '0;
            idx        <= '0;
            sdo        <= '0;
        end else if (clr) begin
            state      <= IDLE;
            busy       <= 1'b0;
            cnt        <= '0;
            data_ready <= 1'b0;
            shift_reg  <= '0;
            idx        <= '0;
            sdo        <= '0;
        end else begin
            case (state)
                IDLE: if (cnv_rise) begin
                    state <= CONV;
                    busy  <= 1'b1;
                    cnt   <= CW'(CNV_CYCLES - 1);
                end
                CONV: if (cnt == '0) begin
                    state      <= READY;
                    busy       <= 1'b0;
                    shift_reg  <= sample_data;
                    idx        <= IW'(DATA_WIDTH);
                    data_ready <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                READY: if (cnv_rise) begin
                    // Restart drops whatever of the previous sample was not yet read.
                    state      <= CONV;
                    busy       <= 1'b1;
                    cnt        <= CW'(CNV_CYCLES - 1);
                    data_ready <= 1'b0;
                    idx        <= '0;
                end else if (readout_step) begin
                    if (idx == '0) begin
                        data_ready <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        sdo       <= sdo_next;
                        shift_reg <= shift_reg << n_lanes;
                        idx       <= (idx > IW'(n_lanes)) ? idx - IW'(n_lanes) : '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_target.sv
// tb/tb_adc_spi_target.sv - scoreboard bench for adc_spi_target
module tb_adc_spi_target;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        spi_resetn = 1'b1;
    logic        cnv = 1'b0;
    logic        sck = 1'b0;
    logic        csn = 1'b1;
    logic        sdi = 1'b0;
    logic [31:0] sample_data = '0;
    logic        busy;
    logic [3:0]  sdo;
    logic [23:0] reg_cmd;
    logic        reg_cmd_stb;
    logic [1:0]  lane_md;
    logic        reg_mode;

    always #5 clk = ~clk;

    adc_spi_target #(.DATA_WIDTH(32), .CNV_CYCLES(28), .SYNC_STAGES(2)) dut (
        .clk(clk), .resetn(resetn), .spi_resetn(spi_resetn), .cnv(cnv), .busy(busy),
        .sck(sck), .csn(csn), .sdi(sdi), .sdo(sdo), .sample_data(sample_data),
        .reg_cmd(reg_cmd), .reg_cmd_stb(reg_cmd_stb), .lane_md(lane_md), .reg_mode(reg_mode));

    typedef struct packed {
        logic [23:0] cmd;
        logic        mode;
        logic [1:0]  lane;
    } cmd_exp_t;

    int          checks = 0;
    int          errors = 0;
    cmd_exp_t    exp_cmd_q[$];
    int          exp_busy_q[$];
    logic [31:0] exp_word_q[$];
    logic [31:0] rx_word_q[$];
    logic        cur_mode = 1'b0;
    logic [1:0]  cur_lane = 2'b00;
    logic [31:0] acc = '0;
    int          acc_bits = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event without expectation or timeout", name);
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : monitor
        cmd_exp_t e;
        int busy_len;
        logic [31:0] w;
        busy_len = 0;
        forever begin
            @(negedge clk);
            if (!resetn) busy_len = 0;
            if (reg_cmd_stb) begin
                if (exp_cmd_q.size() == 0) fail_now("unexpected_stb");
                else begin
                    e = exp_cmd_q.pop_front();
                    check("reg_cmd_mode_lane", {reg_cmd, reg_mode, lane_md}, e);
                end
            end
            if (busy) busy_len++;
            else if (busy_len > 0) begin
                if (exp_busy_q.size() == 0) fail_now("unexpected_busy");
                else check("busy_len", busy_len, exp_busy_q.pop_front());
                busy_len = 0;
            end
            if (rx_word_q.size() > 0) begin
                w = rx_word_q.pop_front();
                if (exp_word_q.size() == 0) fail_now("unexpected_word");
                else check("rx_word", w, exp_word_q.pop_front());
            end
        end
    end

    task automatic send_cmd(input logic [23:0] c, input logic exp_mode, input logic [1:0] exp_lane);
        csn = 1'b0;
        clks(HALF);
        for (int i = 23; i >= 0; i--) begin
            sdi = c[i];
            clks(HALF);
            sck = 1'b1;
            clks(HALF);
            sck = 1'b0;
        end
        clks(HALF);
        cur_mode = exp_mode;
        cur_lane = exp_lane;
        exp_cmd_q.push_back({c, exp_mode, exp_lane});
        csn = 1'b1;
        sdi = 1'b0;
        clks(HALF);
    endtask

    task automatic burst(input int nsck, input int lanes, input bit collect);
        csn = 1'b0;
        clks(HALF);
        for (int i = 0; i < nsck; i++) begin
            sck = 1'b1;
            clks(HALF);
            if (collect && acc_bits < 32)
                for (int k = 0; k < lanes; k++) begin
                    acc = {acc[30:0], sdo[k]};
                    acc_bits++;
                end
            sck = 1'b0;
            clks(HALF);
        end
        exp_cmd_q.push_back({24'h0, cur_mode, cur_lane});
        csn = 1'b1;
        clks(HALF);
        if (acc_bits == 32) begin
            rx_word_q.push_back(acc);
            acc_bits = 0;
        end
    endtask

    task automatic convert(input logic [31:0] s, input bit expect_word, input bit retrig);
        int t;
        sample_data = s;
        if (expect_word) exp_word_q.push_back(s);
        exp_busy_q.push_back(28);
        cnv = 1'b1;
        clks(4);
        cnv = 1'b0;
        if (retrig) begin
            clks(6);
            cnv = 1'b1;
            clks(4);
            cnv = 1'b0;
        end
        t = 0;
        while (busy && t < 200) begin
            clks(1);
            t++;
        end
        if (t >= 200) fail_now("busy_timeout");
        clks(4);
    endtask

    initial begin
        clks(4);
        check("rst_busy", busy, 0);
        check("rst_sdo", sdo, 0);
        check("rst_reg_cmd", reg_cmd, 0);
        check("rst_stb", reg_cmd_stb, 0);
        check("rst_lane_md", lane_md, 0);
        check("rst_reg_mode", reg_mode, 0);
        resetn = 1'b1;
        clks(10);

        send_cmd(24'hA00000, 1'b1, 2'b00);
        send_cmd(24'h002080, 1'b1, 2'b10);
        send_cmd(24'h001501, 1'b1, 2'b10);
        send_cmd(24'h001401, 1'b0, 2'b10);

        // 4-lane readout split by a csn rise, then extra sck must hold sdo
        convert(32'h8BADF00D, 1'b1, 1'b0);
        burst(3, 4, 1'b1);
        burst(5, 4, 1'b1);
        burst(2, 4, 1'b0);
        check("sdo_hold_4lane", sdo, 4'b1011);

        // restart after 3 nibbles
        convert(32'h12345678, 1'b0, 1'b0);
        burst(3, 4, 1'b0);
        convert(32'hA5C30F96, 1'b1, 1'b0);
        burst(8, 4, 1'b1);

        // 1-lane readout with a cnv during CONV
        send_cmd(24'hA00000, 1'b1, 2'b10);
        send_cmd(24'h002000, 1'b1, 2'b00);
        send_cmd(24'h001401, 1'b0, 2'b00);
        convert(32'h0023FF42, 1'b1, 1'b1);
        burst(32, 1, 1'b1);
        burst(2, 1, 1'b0);
        check("sdo_hold_1lane", sdo, 4'b0000);

        // 2-lane partial readout, then reset
        send_cmd(24'hA00000, 1'b1, 2'b00);
        send_cmd(24'h002040, 1'b1, 2'b01);
        send_cmd(24'h001401, 1'b0, 2'b01);
        convert(32'hFFFFFFFF, 1'b0, 1'b0);
        csn = 1'b0;
        clks(HALF);
        repeat (2) begin
            sck = 1'b1;
            clks(HALF);
            sck = 1'b0;
            clks(HALF);
        end
        check("sdo_2lane", sdo, 4'b0011);
        resetn = 1'b0;
        #1;
        check("reset_mid_readout", {sdo, lane_md, reg_mode, busy}, 8'h00);
        clks(3);
        resetn = 1'b1;
        cur_mode = 1'b0;
        cur_lane = 2'b00;
        clks(HALF);
        exp_cmd_q.push_back({24'h0, 1'b0, 2'b00});
        csn = 1'b1;
        clks(20);

        check("cmd_q_drained", exp_cmd_q.size(), 0);
        check("busy_q_drained", exp_busy_q.size(), 0);
        check("word_q_drained", exp_word_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
